dp_issue_ctrl: RTL and testbench
================================

// Module: dp_issue_ctrl
// PURPOSE
//  Issue/writeback controller directly upstream of Shift and ALU in the ARM model.
//  Accepts one ARM data-processing instruction per transaction and reads operands from the register file.
//  Drives SHIFT_OP/Shift_Num/Shift_Data/ALU_OP/A plus the current CF/VF, captures F/NZCV, then writes Rd and updates CPSR flags.
//  Shift is registered (one clk); ALU is combinational.
// PARAMETERS
//  DW      32  datapath width
//  RA_W    4   register address width (r0..r15)
// PORTS
//  clk          in   1   system clock
//  rst          in   1   synchronous active-high reset
//  instr_valid  in   1   instruction offered
//  instr        in   32  ARM DP instruction word
//  instr_ready  out  1   block idle, can accept
//  rf_rn_addr   out  4   instr[19:16]
//  rf_rm_addr   out  4   instr[3:0]
//  rf_rs_addr   out  4   instr[11:8]
//  rf_rn_data   in   32  combinational read data (Rn, Rm, Rs)
//  rf_rm_data   in   32
//  rf_rs_data   in   32
//  shift_op     out  3   to Shift SHIFT_OP
//  shift_num    out  8   to Shift Shift_Num
//  shift_data   out  32  to Shift Shift_Data
//  alu_op       out  4   to ALU ALU_OP = instr[24:21]
//  alu_a        out  32  to ALU A = Rn data
//  cf, vf       out  1   current CPSR C, V to Shift/ALU
//  alu_f        in   32  ALU F
//  alu_nzcv     in   4   ALU NZCV
//  rf_we        out  1   one-cycle register write strobe
//  rf_waddr     out  4   Rd = instr[15:12]
//  rf_wdata     out  32  captured alu_f
//  nzcv         out  4   architectural flags
//  done         out  1   one-cycle pulse: instruction retired (write and/or flag update)
//  skipped      out  1   one-cycle pulse: condition failed
//  illegal      out  1   one-cycle pulse: non-DP encoding rejected
// BEHAVIOUR
//  Reset: state IDLE, instr_ready=1, nzcv=0000, all strobes 0, latched instr=0.
//  FSM: IDLE -(valid&ready, latch instr)-> EXEC -> WB -> IDLE. instr_ready=1 only in IDLE.
//  EXEC: shifter operands driven from latched instr.
//   - I=1 (bit25): shift_data={24'b0,imm8}, shift_op=3'b111, shift_num={3'b0,rot,1'b0}.
//   - I=0: shift_data=Rm; shift_op=instr[6:4].
//   - shift_num=Rs[7:0] if instr[4]=1, else {3'b0,instr[11:7]}.
//   - Illegal: instr[27:26]!=00, or I=0 & instr[7:4]=1001. Pulse illegal and go to IDLE; no write, no flag update.
//   - Condition fail: pulse skipped and go to IDLE.
//  WB (2 clk after accept): alu_op/alu_a held; capture alu_f, alu_nzcv; pulse done.
//   - rf_we=1 unless opcode is 10xx (TST/TEQ/CMP/CMN).
//   - If S=1 (bit20): nzcv<=alu_nzcv. Flags are visible the cycle after WB.
//   - Rd=15 is written like any register; PC semantics live elsewhere.
//  Latency: accept at cycle 0 -> done/rf_we at cycle 2 -> next accept at cycle 3.
//  instr changes while busy: ignored (latched copy used). rst in EXEC/WB: abort with no write; flags reset.
// CONFIGURATION
//  DP_COND_EXEC_EN defined: instr[31:28] evaluated against nzcv (EQ..AL; NV treated as fail).
//  Undefined: every instruction executes as AL; skipped is tied 0.
// STRUCTURE
//  Package dp_pkg: state enum {IDLE,EXEC,WB}, COND_* codes, OP_* opcodes, SH_ROR_REG=3'b111.
//  Sub-module dp_cond_check: cond[3:0], nzcv[3:0] -> pass; combinational.
// TESTING
//  ADDS r1,r2,r3 (0xE0921003), r2=5, r3=7 -> rf_we@c2, r1=0x0000000C, nzcv=0000.
//  CMP r0,#1 (0xE3500001), r0=1 -> no rf_we, done@c2, nzcv=0110.
//  nzcv=0100, MOVNE r4,#5 (0x13A04005) -> skipped@c1, no rf_we, nzcv unchanged (macro on).
//  MOV r5,#0xFF000000 (0xE3A054FF) -> shift_op=111, shift_num=8, r5=0xFF000000.
//  MOV r6,r7,LSL r8 (0xE1A06817), r7=1, r8=40 -> shift_num=40, r6=0.
//  rst asserted in EXEC -> no rf_we, nzcv=0000, instr_ready=1 next cycle; valid held while busy -> single accept.

Source files
------------

// File: rtl/dp_pkg.sv
// Shared types and encodings for the data-processing issue/writeback controller.
package dp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_EOR = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_RSB = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_ADC = 4'h5;
  localparam logic [3:0] OP_SBC = 4'h6;
  localparam logic [3:0] OP_RSC = 4'h7;
  localparam logic [3:0] OP_TST = 4'h8;
  localparam logic [3:0] OP_TEQ = 4'h9;
  localparam logic [3:0] OP_CMP = 4'hA;
  localparam logic [3:0] OP_CMN = 4'hB;
  localparam logic [3:0] OP_ORR = 4'hC;
  localparam logic [3:0] OP_MOV = 4'hD;
  localparam logic [3:0] OP_BIC = 4'hE;
  localparam logic [3:0] OP_MVN = 4'hF;

  // Rotated-immediate operands reuse the register-ROR shifter mode.
  localparam logic [2:0] SH_ROR_REG = 3'b111;

  // Anything outside the DP class, plus the multiply pattern that shares its space.
  function automatic logic is_illegal(input logic [31:0] ins);
    return (ins[27:26] != 2'b00) || (!ins[25] && (ins[7:4] == 4'b1001));
  endfunction

  // Compare/test opcodes only update flags.
  function automatic logic writes_rd(input logic [3:0] op);
    return !(op inside {OP_TST, OP_TEQ, OP_CMP, OP_CMN});
  endfunction

endpackage

// File: rtl/dp_cond_check.sv
// Combinational ARM condition-code evaluator: pass=1 when cond holds for nzcv.
module dp_cond_check
  import dp_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n, z, c, v;
  assign {n, z, c, v} = nzcv;

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/dp_issue_ctrl.sv
// Issue/writeback controller feeding the registered Shift and combinational ALU.
// Define DP_COND_EXEC_EN to evaluate instr[31:28] against the flags; otherwise all execute as AL.
module dp_issue_ctrl
  import dp_pkg::*;
#(
  parameter int DW   = 32,
  parameter int RA_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  input  logic [31:0]     instr,
  output logic            instr_ready,
  output logic [RA_W-1:0] rf_rn_addr,
  output logic [RA_W-1:0] rf_rm_addr,
  output logic [RA_W-1:0] rf_rs_addr,
  input  logic [DW-1:0]   rf_rn_data,
  input  logic [DW-1:0]   rf_rm_data,
  input  logic [DW-1:0]   rf_rs_data,
  output logic [2:0]      shift_op,
  output logic [7:0]      shift_num,
  output logic [DW-1:0]   shift_data,
  output logic [3:0]      alu_op,
  output logic [DW-1:0]   alu_a,
  output logic            cf,
  output logic            vf,
  input  logic [DW-1:0]   alu_f,
  input  logic [3:0]      alu_nzcv,
  output logic            rf_we,
  output logic [RA_W-1:0] rf_waddr,
  output logic [DW-1:0]   rf_wdata,
  output logic [3:0]      nzcv,
  output logic            done,
  output logic            skipped,
  output logic            illegal
);

  state_t      state, state_next;
  logic [31:0] instr_q;
  logic [3:0]  nzcv_q;
  logic        cond_pass;
  logic        bad_enc;

`ifdef DP_COND_EXEC_EN
  dp_cond_check u_cond (
    .cond (instr_q[31:28]),
    .nzcv (nzcv_q),
    .pass (cond_pass)
  );
  logic unused_bits;
  assign unused_bits = ^rf_rs_data[DW-1:8];
`else
  assign cond_pass = 1'b1;
  logic unused_bits;
  assign unused_bits = ^{rf_rs_data[DW-1:8], instr_q[31:28]};
`endif

  assign bad_enc = is_illegal(instr_q);

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      instr_q <= '0;
      nzcv_q  <= '0;
    end else begin
      state <= state_next;
      if (instr_valid && instr_ready) instr_q <= instr;
      if (state == WB && instr_q[20]) nzcv_q <= alu_nzcv;
    end
  end

  // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (instr_valid) state_next = EXEC;
      EXEC:    state_next = (bad_enc || !cond_pass) ? IDLE : WB;
      WB:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    instr_ready = 1'b0;
    illegal     = 1'b0;
    skipped     = 1'b0;
    done        = 1'b0;
    rf_we       = 1'b0;
    case (state)
      IDLE: instr_ready = 1'b1;
      EXEC: begin
        illegal = bad_enc;
        skipped = !bad_enc && !cond_pass;
      end
      WB: begin
        done  = 1'b1;
        rf_we = writes_rd(instr_q[24:21]);
      end
      default: ;
    endcase
  end

  // Operand routing is held from the latched word for the whole EXEC/WB window.
  always_comb begin
    shift_data = rf_rm_data;
    shift_op   = instr_q[6:4];
    shift_num  = {3'b000, instr_q[11:7]};
    if (instr_q[25]) begin
      shift_data = DW'(instr_q[7:0]);
      shift_op   = SH_ROR_REG;
      shift_num  = {3'b000, instr_q[11:8], 1'b0};
    end else if (instr_q[4]) begin
      shift_num = rf_rs_data[7:0];
    end
  end

  assign rf_rn_addr = RA_W'(instr_q[19:16]);
  assign rf_rm_addr = RA_W'(instr_q[3:0]);
  assign rf_rs_addr = RA_W'(instr_q[11:8]);
  assign alu_op     = instr_q[24:21];
  assign alu_a      = rf_rn_data;
  assign cf         = nzcv_q[1];
  assign vf         = nzcv_q[0];
  assign nzcv       = nzcv_q;
  assign rf_waddr   = RA_W'(instr_q[15:12]);
  assign rf_wdata   = alu_f;

endmodule

// File: tb/tb_dp_issue_ctrl.sv
// Self-checking bench for dp_issue_ctrl with behavioural register file, shifter and ALU.
module tb_dp_issue_ctrl;

  localparam int K_NONE  = 0;
  localparam int K_DONE  = 1;
  localparam int K_SKIP  = 2;
  localparam int K_ILL   = 3;
  localparam int K_MULTI = 4;

  typedef struct {
    int          kind;
    int          kcyc;
    int          we_cnt;
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  nz;
    logic        ready3;
    logic [2:0]  sop;
    logic [7:0]  snum;
  } res_t;

  typedef struct {
    string       name;
    logic [31:0] ins;
    res_t        exp;
    bit          chk_sh;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [3:0]  rf_rn_addr, rf_rm_addr, rf_rs_addr;
  logic [31:0] rf_rn_data, rf_rm_data, rf_rs_data;
  logic [2:0]  shift_op;
  logic [7:0]  shift_num;
  logic [31:0] shift_data;
  logic [3:0]  alu_op;
  logic [31:0] alu_a;
  logic        cf, vf;
  logic [31:0] alu_f;
  logic [3:0]  alu_nzcv;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [3:0]  nzcv;
  logic        done, skipped, illegal;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dp_issue_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .rf_rn_addr  (rf_rn_addr),
    .rf_rm_addr  (rf_rm_addr),
    .rf_rs_addr  (rf_rs_addr),
    .rf_rn_data  (rf_rn_data),
    .rf_rm_data  (rf_rm_data),
    .rf_rs_data  (rf_rs_data),
    .shift_op    (shift_op),
    .shift_num   (shift_num),
    .shift_data  (shift_data),
    .alu_op      (alu_op),
    .alu_a       (alu_a),
    .cf          (cf),
    .vf          (vf),
    .alu_f       (alu_f),
    .alu_nzcv    (alu_nzcv),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .nzcv        (nzcv),
    .done        (done),
    .skipped     (skipped),
    .illegal     (illegal)
  );

  // ---------------- environment: register file, shifter, ALU ----------------
  logic [31:0] rf [16];
  logic        pre_we = 1'b0;
  logic [3:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;
  int          we_seen = 0;
  int          acc_seen = 0;
  logic [31:0] sh_q = '0;

  always @(posedge clk) begin
    if (rf_we) rf[rf_waddr] <= rf_wdata;
    else if (pre_we) rf[pre_addr] <= pre_data;
    if (rf_we) we_seen <= we_seen + 1;
    if (!rst && instr_valid && instr_ready) acc_seen <= acc_seen + 1;
  end

  assign rf_rn_data = rf[rf_rn_addr];
  assign rf_rm_data = rf[rf_rm_addr];
  assign rf_rs_data = rf[rf_rs_addr];

  function automatic logic [31:0] env_shift(input logic [2:0] op, input logic [7:0] n,
                                            input logic [31:0] x);
    int r;
    r = int'(n) % 32;
    case (op[2:1])
      2'd0:    return x << n;
      2'd1:    return x >> n;
      2'd2:    return $signed(x) >>> n;
      default: return (x >> r) | (x << (32 - r));
    endcase
  endfunction

  function automatic logic [35:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic c, input logic v);
    logic [32:0] s;
    logic [31:0] x, y, f;
    logic        ci, arith;
    arith = 1'b1;
    x = a;
    y = b;
    ci = 1'b0;
    case (op)
      4'h2, 4'hA: begin y = ~b; ci = 1'b1; end
      4'h3:       begin x = b; y = ~a; ci = 1'b1; end
      4'h4, 4'hB: ;
      4'h5:       ci = c;
      4'h6:       begin y = ~b; ci = c; end
      4'h7:       begin x = b; y = ~a; ci = c; end
      default:    arith = 1'b0;
    endcase
    s = {1'b0, x} + {1'b0, y} + {32'd0, ci};
    if (arith) begin
      f = s[31:0];
      return {f[31], f == 32'd0, s[32], (x[31] == y[31]) && (f[31] != x[31]), f};
    end
    case (op)
      4'h0, 4'h8: f = a & b;
      4'h1, 4'h9: f = a ^ b;
      4'hC:       f = a | b;
      4'hD:       f = b;
      4'hE:       f = a & ~b;
      default:    f = ~b;
    endcase
    return {f[31], f == 32'd0, c, v, f};
  endfunction

  always @(posedge clk) sh_q <= env_shift(shift_op, shift_num, shift_data);

  always_comb begin
    {alu_nzcv, alu_f} = alu_fn(alu_op, alu_a, sh_q, cf, vf);
  end

  // ---------------- reference model (instruction-level) ----------------
  logic [31:0] model_rf [16];
  logic [3:0]  model_nzcv = 4'b0000;

  function automatic bit cond_ok(input logic [3:0] cc, input logic [3:0] f);
    bit n, z, c, v;
    {n, z, c, v} = f;
    case (cc)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return c;
      4'h3: return !c;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return c && !z;
      4'h9: return !c || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] model_op2(input logic [31:0] ins);
    logic [63:0] dbl;
    logic [31:0] x;
    int          amt;
    if (ins[25]) begin
      dbl = {2{24'd0, ins[7:0]}};
      dbl = dbl >> (2 * int'(ins[11:8]));
      return dbl[31:0];
    end
    x   = model_rf[ins[3:0]];
    amt = ins[4] ? int'(model_rf[ins[11:8]][7:0]) : int'(ins[11:7]);
    case (ins[6:5])
      2'd0: return (amt >= 32) ? 32'd0 : x << amt;
      2'd1: return (amt >= 32) ? 32'd0 : x >> amt;
      2'd2: return (amt >= 32) ? {32{x[31]}} : 32'($signed(x) >>> amt);
      default: begin
        dbl = {x, x} >> (amt % 32);
        return dbl[31:0];
      end
    endcase
  endfunction

  function automatic res_t model(input logic [31:0] ins);
    res_t        r;
    logic [35:0] o;
    bit          pass;
    r = '{default: '0};
    r.ready3 = 1'b1;
    r.nz = model_nzcv;
`ifdef DP_COND_EXEC_EN
    pass = cond_ok(ins[31:28], model_nzcv);
`else
    pass = 1'b1;
`endif
    if (ins[27:26] != 2'b00 || (!ins[25] && ins[7:4] == 4'b1001)) begin
      r.kind = K_ILL;
      r.kcyc = 1;
    end else if (!pass) begin
      r.kind = K_SKIP;
      r.kcyc = 1;
    end else begin
      o = alu_fn(ins[24:21], model_rf[ins[19:16]], model_op2(ins), model_nzcv[1], model_nzcv[0]);
      r.kind   = K_DONE;
      r.kcyc   = 2;
      r.we_cnt = (ins[24:23] == 2'b10) ? 0 : 1;
      r.waddr  = ins[15:12];
      r.wdata  = o[31:0];
      if (ins[20]) r.nz = o[35:32];
    end
    return r;
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_we   = 1'b1;
    pre_addr = a;
    pre_data = d;
    model_rf[a] = d;
    @(posedge clk);
    #1 pre_we = 1'b0;
  endtask

  // Issue one instruction; sample cycles 1 (EXEC), 2 (WB) and 3 (idle again).
  task automatic run_one(input logic [31:0] ins, output res_t o);
    int n;
    o = '{default: '0};
    @(negedge clk);
    instr       = ins;
    instr_valid = 1'b1;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      if (c == 1) begin
        instr_valid = 1'b0;
        instr       = $urandom;
        o.sop       = shift_op;
        o.snum      = shift_num;
      end
      if (rf_we) begin
        o.we_cnt++;
        o.waddr = rf_waddr;
        o.wdata = rf_wdata;
      end
      n = int'(done) + int'(skipped) + int'(illegal);
      if (n != 0 && o.kind == K_NONE) begin
        o.kcyc = c;
        if (n > 1) o.kind = K_MULTI;
        else if (done) o.kind = K_DONE;
        else if (skipped) o.kind = K_SKIP;
        else o.kind = K_ILL;
      end
    end
    @(negedge clk);
    if (rf_we) o.we_cnt++;
    o.nz     = nzcv;
    o.ready3 = instr_ready;
  endtask

  task automatic cmp_res(input string p, input res_t got, input res_t exp, input bit chk_sh);
    check({p, "_kind"}, 64'(got.kind), 64'(exp.kind));
    check({p, "_cycle"}, 64'(got.kcyc), 64'(exp.kcyc));
    check({p, "_we_count"}, 64'(got.we_cnt), 64'(exp.we_cnt));
    if (exp.we_cnt != 0) begin
      check({p, "_waddr"}, 64'(got.waddr), 64'(exp.waddr));
      check({p, "_wdata"}, 64'(got.wdata), 64'(exp.wdata));
    end
    check({p, "_nzcv"}, 64'(got.nz), 64'(exp.nz));
    check({p, "_ready"}, 64'(got.ready3), 64'(exp.ready3));
    if (chk_sh) begin
      check({p, "_shift_op"}, 64'(got.sop), 64'(exp.sop));
      check({p, "_shift_num"}, 64'(got.snum), 64'(exp.snum));
    end
  endtask

  function automatic vec_t mk(input string nm, input logic [31:0] ins, input int kind,
                              input bit we, input logic [3:0] wa, input logic [31:0] wd,
                              input logic [3:0] nz, input bit chk, input logic [2:0] sop,
                              input logic [7:0] snum);
    vec_t v;
    v.name   = nm;
    v.ins    = ins;
    v.chk_sh = chk;
    v.exp    = '{default: '0};
    v.exp.kind   = kind;
    v.exp.kcyc   = (kind == K_DONE) ? 2 : 1;
    v.exp.we_cnt = we ? 1 : 0;
    v.exp.waddr  = wa;
    v.exp.wdata  = wd;
    v.exp.nz     = nz;
    v.exp.ready3 = 1'b1;
    v.exp.sop    = sop;
    v.exp.snum   = snum;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    vec_t vt [12];
    res_t got, exp;
    int   we_base, acc_base;

    vt[0]  = mk("adds_r1",   32'hE0921003, K_DONE, 1, 4'd1,  32'h0000000C, 4'b0000, 1, 3'b000, 8'd0);
    vt[1]  = mk("cmp_r0_1",  32'hE3500001, K_DONE, 0, 4'd0,  32'h0,        4'b0110, 1, 3'b111, 8'd0);
    vt[2]  = mk("mov_imm",   32'hE3A054FF, K_DONE, 1, 4'd5,  32'hFF000000, 4'b0110, 1, 3'b111, 8'd8);
    vt[3]  = mk("mov_lslreg",32'hE1A06817, K_DONE, 1, 4'd6,  32'h0,        4'b0110, 1, 3'b001, 8'd40);
    vt[4]  = mk("ill_class", 32'hE4000000, K_ILL,  0, 4'd0,  32'h0,        4'b0110, 0, 3'b000, 8'd0);
    vt[5]  = mk("ill_mul",   32'hE0010392, K_ILL,  0, 4'd0,  32'h0,        4'b0110, 0, 3'b000, 8'd0);
    vt[6]  = mk("mov_r15",   32'hE1A0F002, K_DONE, 1, 4'd15, 32'd5,        4'b0110, 1, 3'b000, 8'd0);
    vt[7]  = mk("cmn_r2_r3", 32'hE1720003, K_DONE, 0, 4'd0,  32'h0,        4'b0000, 0, 3'b000, 8'd0);
    vt[9]  = mk("movs_r9_0", 32'hE3B09000, K_DONE, 1, 4'd9,  32'h0,        4'b0100, 0, 3'b000, 8'd0);
`ifdef DP_COND_EXEC_EN
    vt[8]  = mk("moveq_z0",  32'h03A04006, K_SKIP, 0, 4'd0,  32'h0,        4'b0000, 0, 3'b000, 8'd0);
    vt[10] = mk("movne_z1",  32'h13A04005, K_SKIP, 0, 4'd0,  32'h0,        4'b0100, 0, 3'b000, 8'd0);
    vt[11] = mk("mov_nv",    32'hF3A04007, K_SKIP, 0, 4'd0,  32'h0,        4'b0100, 0, 3'b000, 8'd0);
`else
    vt[8]  = mk("moveq_al",  32'h03A04006, K_DONE, 1, 4'd4,  32'd6,        4'b0000, 0, 3'b000, 8'd0);
    vt[10] = mk("movne_al",  32'h13A04005, K_DONE, 1, 4'd4,  32'd5,        4'b0100, 0, 3'b000, 8'd0);
    vt[11] = mk("mov_nv_al", 32'hF3A04007, K_DONE, 1, 4'd4,  32'd7,        4'b0100, 0, 3'b000, 8'd0);
`endif

    rst = 1'b1;
    instr_valid = 1'b0;
    instr = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_ready", 64'(instr_ready), 64'd1);
    check("rst_nzcv", 64'(nzcv), 64'd0);
    check("rst_strobes", 64'({rf_we, done, skipped, illegal}), 64'd0);

    preload(4'd0, 32'd1);
    preload(4'd2, 32'd5);
    preload(4'd3, 32'd7);
    preload(4'd7, 32'd1);
    preload(4'd8, 32'd40);

    foreach (vt[i]) begin
      run_one(vt[i].ins, got);
      cmp_res(vt[i].name, got, vt[i].exp, vt[i].chk_sh);
    end

    // Reset while in EXEC: no write, flags cleared, idle next cycle.
    run_one(32'hE3500001, got);
    check("pre_rst_nzcv", 64'(got.nz), 64'b0110);
    we_base = we_seen;
    @(negedge clk);
    instr = 32'hE0921003;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    check("exec_busy_ready", 64'(instr_ready), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ready", 64'(instr_ready), 64'd1);
    check("abort_nzcv", 64'(nzcv), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    repeat (2) @(negedge clk);
    check("abort_no_write", 64'(we_seen - we_base), 64'd0);

    // Valid held high while busy, instr changed mid-flight: single accept, latched copy used.
    acc_base = acc_seen;
    @(negedge clk);
    instr = 32'hE0921003;
    instr_valid = 1'b1;
    @(negedge clk);
    instr = 32'hE3A01055;
    @(negedge clk);
    check("held_done", 64'(done), 64'd1);
    check("held_we", 64'(rf_we), 64'd1);
    check("held_waddr", 64'(rf_waddr), 64'd1);
    check("held_wdata", 64'(rf_wdata), 64'h0000000C);
    @(negedge clk);
    instr_valid = 1'b0;
    check("held_ready_c3", 64'(instr_ready), 64'd1);
    repeat (2) @(negedge clk);
    check("held_single_accept", 64'(acc_seen - acc_base), 64'd1);
    check("held_nzcv", 64'(nzcv), 64'd0);

    // Randomised instructions against the instruction-level model.
    model_nzcv = 4'b0000;
    for (int k = 0; k < 220; k++) begin
      logic [31:0] ins, d;
      ins = $urandom;
      if ($urandom_range(0, 7) != 0) ins[27:26] = 2'b00;
      preload(ins[19:16], $urandom);
      preload(ins[3:0], $urandom);
      d = $urandom;
      if ($urandom_range(0, 1) != 0) d[7:0] = 8'($urandom_range(0, 40));
      preload(ins[11:8], d);
      exp = model(ins);
      run_one(ins, got);
      cmp_res($sformatf("rnd%0d_%h", k, ins), got, exp, 1'b0);
      model_nzcv = exp.nz;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
